fifo_rd_stream_adapter: RTL and testbench
=========================================

# fifo_rd_stream_adapter

Read-side stage placed directly downstream of the team's synchronous FIFO. It issues FIFO read strobes and absorbs the FIFO's one-cycle registered read latency in a small internal skid buffer. It presents the data as a valid/ready stream with burst framing (`m_last`) for the downstream consumer. Full throughput (1 beat/cycle) is sustained while the FIFO is non-empty and `m_ready` is held high.

## Interface
- `WIDTH`, 128, data width; matches the FIFO word width.
- `SKID_DEPTH`, 3, internal buffer entries; minimum 3 for full throughput.
- `BURST_LEN`, 16, beats per burst; `m_last` is flagged on the final beat; ≥1.
- `CNT_W`, 32, width of the beat statistics counter.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rddata`  in  WIDTH  FIFO read data; valid in the cycle after an accepted read.
- `fifo_rden`  out  1  FIFO read strobe.
- `i_flush`  in  1  synchronous flush of buffered data and the burst position.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  output beat data.
- `m_last`  out  1  last beat of the current burst.
- `o_beat_cnt`  out  CNT_W  total beats transferred since reset; wraps.

## Operation
- **Accepted read.** An accepted read is `fifo_rden && !fifo_empty`. Its data is written into the buffer on the next clock edge.
- **Inflight flag.** `inflight` is a 1-bit register set by an accepted read and cleared otherwise.
- **Credit rule.**
  - `fifo_rden = !fifo_empty && !i_flush && (count + inflight) < SKID_DEPTH`.
  - `count` is the buffer occupancy, registered.
  - `fifo_rden` has no combinational path from `m_ready`.
- **Buffer.**
  - Circular, with `wr_idx` and `rd_idx` each wrapping at `SKID_DEPTH`.
  - `count` ranges 0..`SKID_DEPTH` and never overflows, because of the credit rule.
  - A simultaneous push and pop leaves `count` unchanged.
- **Output.**
  - `m_valid = (count != 0)`.
  - `m_data = buf[rd_idx]`.
  - A pop happens on `m_valid && m_ready`.
  - `m_data`/`m_valid` stay stable while `m_valid && !m_ready`.
- **Burst counter.**
  - `beat_idx` counts 0..`BURST_LEN`-1 and advances on each pop.
  - It wraps to 0 after the pop where `beat_idx == BURST_LEN-1`.
  - `m_last = m_valid && (beat_idx == BURST_LEN-1)`.
  - `BURST_LEN=1` gives `m_last` on every beat.
- **Statistics.** `o_beat_cnt` increments on each pop and wraps modulo 2^`CNT_W`.
- **State machine (`state`).**
  - `IDLE`: `count == 0` and `inflight == 0`.
  - `ACTIVE`: data is buffered or inflight.
  - `FLUSH`: entered on `i_flush`.
    - Discards all buffered entries and drops the returning data of any inflight read.
    - Clears `beat_idx`.
    - Holds `fifo_rden` low.
    - Exits to `IDLE` the cycle after `i_flush` deasserts and `inflight == 0`.
- **Reset values** (while `rstn` is low at a clock edge):
  - `fifo_rden=0`, `m_valid=0`, `m_last=0`, `m_data=0`, `o_beat_cnt=0`.
  - `count`, `inflight`, `beat_idx`, `wr_idx`, `rd_idx` all 0; state `IDLE`.
  - Buffer contents are don't-care but must not be visible.
- **Reset mid-operation.** Same result as reset at any time: inflight data is dropped and the FIFO word it carried is lost. The FIFO itself is reset by the same `rstn`.

## Timing
- Read strobe to visibility: `fifo_rden` accepted in cycle N → data in the buffer at the end of N+1 → `m_valid` high in N+2.
  - Minimum FIFO-non-empty to `m_valid` latency is 2 cycles.
- Steady state with `SKID_DEPTH=3`, FIFO non-empty and `m_ready=1`: one beat per cycle, no bubbles.
- A `m_ready` drop stops new reads within one cycle. Up to 1 inflight word then lands in the remaining credit; there is no overflow.
- The FIFO going empty mid-stream produces bubbles only. No data is duplicated or lost.
- `i_flush` takes priority over push and pop in the same cycle. A pop in that cycle is not counted in `o_beat_cnt`.

## Structure
- Shared package `fifo_stream_pkg`:
  - typedef `state_t` {`IDLE`, `ACTIVE`, `FLUSH`}
  - default constants `WIDTH_DEF=128`, `BURST_LEN_DEF=16`, `SKID_DEPTH_MIN=3`
- Sub-module `stream_skid_buf`: the circular buffer with `count`, parameterised by `WIDTH` and `SKID_DEPTH`.
- The top level holds the credit logic, the state machine, the burst counter and the statistics counter.

## Test plan
- **Reset.** Hold `rstn=0` for 3 cycles with FIFO non-empty → `fifo_rden=0`, `m_valid=0`, `o_beat_cnt=0` throughout.
- **Streaming.** Preload FIFO with 32 words 0..31, `m_ready=1` → first `m_valid` 2 cycles after the first `fifo_rden`; 32 consecutive beats in order; `m_last` on words 15 and 31; `o_beat_cnt=32`.
- **Backpressure.** Toggle `m_ready` 1/0 every cycle over 20 words → no loss or duplication; `count` never exceeds 3; `m_data` stable while stalled.
- **Empty boundary.** FIFO holds 1 word, then 5 idle cycles, then 1 word → exactly 2 beats; `m_valid` low in between; `beat_idx=2` afterwards.
- **Flush.** Pulse `i_flush` for 1 cycle with 2 buffered and 1 inflight → `m_valid` low next cycle; the inflight word is discarded; the next beat after refill has `beat_idx=0`.
- **Counter wrap.** `CNT_W=4`, 17 beats → `o_beat_cnt=1`. `BURST_LEN=1` → `m_last` on every beat.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared types and defaults for the FIFO read-side stream adapter.
//   state_t        : adapter state (IDLE / ACTIVE / FLUSH)
//   WIDTH_DEF      : default data width
//   BURST_LEN_DEF  : default beats per burst
//   SKID_DEPTH_MIN : smallest skid depth that sustains one beat per cycle
//   idx_w()        : index width for a counter/pointer over n entries (min 1)
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } state_t;

  localparam int unsigned WIDTH_DEF      = 128;
  localparam int unsigned BURST_LEN_DEF  = 16;
  localparam int unsigned SKID_DEPTH_MIN = 3;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Circular skid buffer holding words returned by the FIFO until the
// downstream consumer accepts them.
//   clk, rstn  : clock, synchronous active-low reset
//   flush      : discard all entries and rewind both pointers
//   push       : write push_data at wr_idx
//   pop        : release the entry at rd_idx (caller guarantees count != 0)
//   count      : occupancy, 0..SKID_DEPTH (caller guarantees no overflow)
//   rd_data    : entry at rd_idx
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned SKID_DEPTH = SKID_DEPTH_MIN,
  parameter int unsigned CW         = $clog2(SKID_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned    IW   = idx_w(SKID_DEPTH);
  localparam logic [IW-1:0]  LAST = IW'(SKID_DEPTH - 1);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wrap_inc(wr_idx);
      if (pop)  rd_idx <= wrap_inc(rd_idx);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the top masks the output while count == 0.
  always_ff @(posedge clk) begin
    if (push && rstn && !flush) mem[wr_idx] <= push_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter for the synchronous FIFO: issues read strobes under a
// credit limit, absorbs the FIFO's one-cycle read latency in a skid buffer
// and presents a valid/ready stream with burst framing.
//   clk, rstn    : clock, synchronous active-low reset
//   fifo_empty   : FIFO empty flag
//   fifo_rddata  : FIFO read data, valid the cycle after an accepted read
//   fifo_rden    : FIFO read strobe
//   i_flush      : drop buffered/inflight data and restart the burst
//   m_valid, m_ready, m_data, m_last : output stream
//   o_beat_cnt   : beats transferred since reset (wraps)
module fifo_rd_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned SKID_DEPTH = SKID_DEPTH_MIN,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rddata,
  output logic             fifo_rden,
  input  logic             i_flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] o_beat_cnt
);

  localparam int unsigned   CW        = $clog2(SKID_DEPTH + 1);
  localparam int unsigned   BW        = idx_w(BURST_LEN);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [CW:0]   DEPTH_L   = (CW + 1)'(SKID_DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t           state_q;
  state_t           state_d;
  logic             inflight;
  logic [BW-1:0]    beat_idx;
  logic [CW-1:0]    count;
  logic [CW:0]      credit_used;
  logic [WIDTH-1:0] buf_data;
  logic             rd_accept;
  logic             push;
  logic             pop;
  logic             busy_next;

  // Credit covers both stored entries and the word still in the FIFO's read
  // register, so a returning word always has a free slot.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};

  // rstn gates the strobe so no read is accepted while reset is held.
  assign fifo_rden = rstn && !fifo_empty && !i_flush && (state_q != FLUSH)
                   && (credit_used < DEPTH_L);
  assign rd_accept = fifo_rden;

  // Data returning from a read accepted before a flush is dropped here.
  assign push = inflight && !i_flush && (state_q != FLUSH);

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? buf_data : '0;
  assign m_last  = m_valid && (beat_idx == BEAT_LAST);
  assign pop     = m_valid && m_ready && !i_flush;

  assign busy_next = rd_accept || push || ((count != '0) && !(pop && (count == ONE)));

  stream_skid_buf #(
    .WIDTH      (WIDTH),
    .SKID_DEPTH (SKID_DEPTH),
    .CW         (CW)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (i_flush),
    .push      (push),
    .push_data (fifo_rddata),
    .pop       (pop),
    .count     (count),
    .rd_data   (buf_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACTIVE: state_d = busy_next ? ACTIVE : IDLE;
      FLUSH:        if (!inflight) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    if (i_flush) state_d = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      inflight   <= 1'b0;
      beat_idx   <= '0;
      o_beat_cnt <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= rd_accept;
      if (i_flush)
        beat_idx <= '0;
      else if (pop)
        beat_idx <= (beat_idx == BEAT_LAST) ? '0 : beat_idx + 1'b1;
      if (pop) o_beat_cnt <= o_beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter. Two instances: a 32-bit
// one with default burst/skid/counter sizes, and a 16-bit one with
// BURST_LEN=1 and CNT_W=4. Each is fed by a queue-like FIFO model with a
// registered read port; a scoreboard of words written to the FIFO predicts
// the output stream.
module tb_fifo_rd_stream_adapter;

  localparam int unsigned W0  = 32;
  localparam int unsigned BL0 = 16;
  localparam int unsigned W1  = 16;
  localparam int unsigned BL1 = 1;
  localparam int unsigned CW1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic          fifo_empty0, fifo_rden0, flush0, m_valid0, m_ready0, m_last0;
  logic [W0-1:0] fifo_rddata0, m_data0;
  logic [31:0]   o_beat_cnt0;

  logic           fifo_empty1, fifo_rden1, flush1, m_valid1, m_ready1, m_last1;
  logic [W1-1:0]  fifo_rddata1, m_data1;
  logic [CW1-1:0] o_beat_cnt1;

  fifo_rd_stream_adapter #(
    .WIDTH(W0), .SKID_DEPTH(3), .BURST_LEN(BL0), .CNT_W(32)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty0), .fifo_rddata(fifo_rddata0),
    .fifo_rden(fifo_rden0), .i_flush(flush0), .m_valid(m_valid0), .m_ready(m_ready0),
    .m_data(m_data0), .m_last(m_last0), .o_beat_cnt(o_beat_cnt0)
  );

  fifo_rd_stream_adapter #(
    .WIDTH(W1), .SKID_DEPTH(3), .BURST_LEN(BL1), .CNT_W(CW1)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty1), .fifo_rddata(fifo_rddata1),
    .fifo_rden(fifo_rden1), .i_flush(flush1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_data(m_data1), .m_last(m_last1), .o_beat_cnt(o_beat_cnt1)
  );

  // FIFO models: registered read, data valid the cycle after the strobe.
  logic [W0-1:0] fmem0 [1024];
  int unsigned   fwp0 = 0;
  int unsigned   frp0 = 0;
  assign fifo_empty0 = (fwp0 == frp0);
  always @(posedge clk) begin
    if (fifo_rden0 === 1'b1 && fwp0 != frp0) begin
      fifo_rddata0 <= fmem0[frp0];
      frp0 <= frp0 + 1;
    end
  end

  logic [W1-1:0] fmem1 [64];
  int unsigned   fwp1 = 0;
  int unsigned   frp1 = 0;
  assign fifo_empty1 = (fwp1 == frp1);
  always @(posedge clk) begin
    if (fifo_rden1 === 1'b1 && fwp1 != frp1) begin
      fifo_rddata1 <= fmem1[frp1];
      frp1 <= frp1 + 1;
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state for instance 0.
  logic [W0-1:0] exp0 [$];
  int unsigned   exp_beat0 = 0;
  logic [31:0]   exp_cnt0  = '0;
  int            cyc = 0;
  int            first_rd0, first_val0, last_pop0;
  int unsigned   pops0, valids0;
  logic          prev_stall0 = 1'b0;
  logic [W0-1:0] prev_data0;

  task automatic push0(input logic [W0-1:0] w);
    fmem0[fwp0] = w;
    fwp0 = fwp0 + 1;
    exp0.push_back(w);
  endtask

  // Everything still in the FIFO model will be delivered; anything already
  // read out of it was discarded by the DUT.
  task automatic resync0();
    exp0.delete();
    for (int unsigned j = frp0; j < fwp0; j++) exp0.push_back(fmem0[j]);
    exp_beat0 = 0;
    prev_stall0 = 1'b0;
  endtask

  // Enters and leaves just after a rising edge. mode: 0 ready high,
  // 1 ready toggling, 2 ready random.
  task automatic run0(input int unsigned ncyc, input int unsigned mode);
    logic [W0-1:0] w;
    for (int unsigned i = 0; i < ncyc; i++) begin
      case (mode)
        0:       m_ready0 = 1'b1;
        1:       m_ready0 = i[0];
        default: m_ready0 = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      cyc++;
      if (fifo_rden0 === 1'b1 && first_rd0 < 0) first_rd0 = cyc;
      if (m_valid0 === 1'b1) begin
        valids0++;
        if (first_val0 < 0) first_val0 = cyc;
      end
      if (prev_stall0) begin
        n_tests++;
        if (m_valid0 !== 1'b1 || m_data0 !== prev_data0) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", m_valid0, m_data0, prev_data0);
        end
      end
      n_tests++;
      if (m_last0 !== (m_valid0 && exp_beat0 == BL0 - 1)) begin
        n_fail++;
        $display("FAIL m_last: got %b, required %b (beat %0d)", m_last0, (m_valid0 && exp_beat0 == BL0 - 1), exp_beat0);
      end
      n_tests++;
      if (o_beat_cnt0 !== exp_cnt0) begin
        n_fail++;
        $display("FAIL beat_cnt: got %0d, required %0d", o_beat_cnt0, exp_cnt0);
      end
      if (m_valid0 === 1'b1 && m_ready0) begin
        n_tests++;
        if (exp0.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got data %h, required no beat", m_data0);
        end else begin
          w = exp0.pop_front();
          if (m_data0 !== w) begin
            n_fail++;
            $display("FAIL beat_data: got %h, required %h", m_data0, w);
          end
        end
        exp_beat0 = (exp_beat0 + 1) % BL0;
        exp_cnt0  = exp_cnt0 + 1;
        pops0++;
        last_pop0 = cyc;
      end
      prev_stall0 = (m_valid0 === 1'b1) && !m_ready0;
      prev_data0  = m_data0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    for (int unsigned k = 0; k < 32; k++) push0(W0'(k));
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (fifo_rden0 !== 1'b0 || m_valid0 !== 1'b0 || m_last0 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctl: rden=%b valid=%b last=%b, required 0 0 0", fifo_rden0, m_valid0, m_last0);
      end
      n_tests++;
      if (o_beat_cnt0 !== '0 || m_data0 !== '0) begin
        n_fail++;
        $display("FAIL reset_out: cnt=%0d data=%h, required 0 0", o_beat_cnt0, m_data0);
      end
      n_tests++;
      if (fifo_rden1 !== 1'b0 || m_valid1 !== 1'b0 || o_beat_cnt1 !== '0) begin
        n_fail++;
        $display("FAIL reset_dut1: rden=%b valid=%b cnt=%0d, required 0 0 0", fifo_rden1, m_valid1, o_beat_cnt1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    first_rd0 = -1; first_val0 = -1; last_pop0 = -1; pops0 = 0;
    rstn = 1'b1;
    run0(40, 0);
    n_tests++;
    if (first_val0 - first_rd0 !== 2) begin
      n_fail++;
      $display("FAIL first_latency: got %0d cycles, required 2", first_val0 - first_rd0);
    end
    n_tests++;
    if (pops0 !== 32 || last_pop0 - first_val0 + 1 !== 32) begin
      n_fail++;
      $display("FAIL stream_rate: got %0d beats over %0d cycles, required 32 over 32", pops0, last_pop0 - first_val0 + 1);
    end
    n_tests++;
    if (o_beat_cnt0 !== 32'd32) begin
      n_fail++;
      $display("FAIL stream_cnt: got %0d, required 32", o_beat_cnt0);
    end
  endtask

  task automatic test_empty_boundary();
    int unsigned v;
    pops0 = 0;
    push0(W0'($urandom));
    run0(6, 0);
    v = valids0;
    run0(5, 0);
    n_tests++;
    if (valids0 !== v) begin
      n_fail++;
      $display("FAIL empty_gap: got %0d valid cycles, required 0", valids0 - v);
    end
    push0(W0'($urandom));
    run0(6, 0);
    n_tests++;
    if (pops0 !== 2 || exp0.size() != 0) begin
      n_fail++;
      $display("FAIL empty_beats: got %0d beats, required 2", pops0);
    end
  endtask

  task automatic test_backpressure();
    for (int unsigned m = 1; m <= 2; m++) begin
      pops0 = 0;
      for (int unsigned k = 0; k < 20; k++) push0(W0'($urandom));
      run0(100, m);
      n_tests++;
      if (pops0 !== 20 || exp0.size() != 0) begin
        n_fail++;
        $display("FAIL backpressure_mode%0d: got %0d beats, required 20", m, pops0);
      end
    end
  endtask

  task automatic test_flush();
    int unsigned   rp_start;
    logic [W0-1:0] first_w;
    // Two words buffered and one inflight when the flush lands.
    m_ready0 = 1'b0;
    rp_start = frp0;
    first_w = W0'($urandom);
    push0(first_w);
    for (int unsigned k = 0; k < 5; k++) push0(W0'($urandom));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush0 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (m_valid0 !== 1'b1 || m_data0 !== first_w || fifo_rden0 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pre: valid=%b data=%h rden=%b, required 1 %h 0", m_valid0, m_data0, fifo_rden0, first_w);
    end
    @(posedge clk); #1;
    flush0 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m_valid0 !== 1'b0 || fifo_rden0 !== 1'b0 || frp0 - rp_start !== 3) begin
      n_fail++;
      $display("FAIL flush_post: valid=%b rden=%b reads=%0d, required 0 0 3", m_valid0, fifo_rden0, frp0 - rp_start);
    end
    resync0();
    @(posedge clk); #1;
    pops0 = 0;
    run0(15, 0);
    n_tests++;
    if (pops0 !== 3 || exp0.size() != 0) begin
      n_fail++;
      $display("FAIL flush_refill: got %0d beats, required 3", pops0);
    end
    // Flush while a beat is being accepted: that beat is not counted.
    for (int unsigned k = 0; k < 8; k++) push0(W0'($urandom));
    run0(5, 0);
    m_ready0 = 1'b1;
    flush0 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (m_valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pop_valid: got %b, required 1", m_valid0);
    end
    @(posedge clk); #1;
    flush0 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_beat_cnt0 !== exp_cnt0 || m_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pop_cnt: cnt=%0d valid=%b, required %0d 0", o_beat_cnt0, m_valid0, exp_cnt0);
    end
    resync0();
    @(posedge clk); #1;
    run0(20, 0);
    n_tests++;
    if (exp0.size() != 0) begin
      n_fail++;
      $display("FAIL flush_drain: %0d words undelivered, required 0", exp0.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int unsigned k = 0; k < 10; k++) push0(W0'($urandom));
    run0(4, 0);
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fifo_rden0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_rden: got %b, required 0", fifo_rden0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (m_valid0 !== 1'b0 || o_beat_cnt0 !== '0 || o_beat_cnt1 !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: valid=%b cnt0=%0d cnt1=%0d, required 0 0 0", m_valid0, o_beat_cnt0, o_beat_cnt1);
    end
    resync0();
    exp_cnt0 = '0;
    @(posedge clk); #1;
    run0(25, 0);
    n_tests++;
    if (exp0.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_drain: %0d words undelivered, required 0", exp0.size());
    end
  endtask

  task automatic test_cnt_wrap();
    logic [W1-1:0]  exp1 [$];
    logic [W1-1:0]  w;
    logic [CW1-1:0] exp_cnt1 = '0;
    int unsigned    pops1 = 0;
    for (int unsigned k = 0; k < 17; k++) begin
      w = W1'($urandom);
      fmem1[fwp1] = w;
      fwp1 = fwp1 + 1;
      exp1.push_back(w);
    end
    m_ready1 = 1'b1;
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid1 === 1'b1) begin
        n_tests++;
        if (m_last1 !== 1'b1) begin
          n_fail++;
          $display("FAIL burst1_last: got %b, required 1", m_last1);
        end
        n_tests++;
        if (exp1.size() == 0) begin
          n_fail++;
          $display("FAIL burst1_extra: got %h, required no beat", m_data1);
        end else begin
          w = exp1.pop_front();
          if (m_data1 !== w) begin
            n_fail++;
            $display("FAIL burst1_data: got %h, required %h", m_data1, w);
          end
        end
        exp_cnt1 = exp_cnt1 + 1'b1;
        pops1++;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (o_beat_cnt1 !== exp_cnt1 || pops1 !== 17) begin
      n_fail++;
      $display("FAIL cnt_wrap: got cnt %0d after %0d beats, required %0d after 17", o_beat_cnt1, pops1, exp_cnt1);
    end
  endtask

  initial begin
    rstn = 1'b0;
    flush0 = 1'b0; m_ready0 = 1'b1;
    flush1 = 1'b0; m_ready1 = 1'b0;
    test_reset();
    test_streaming();
    test_empty_boundary();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
